wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
Writeback arbiter that sits directly upstream of the integer register file and drives its single write port. It merges two result producers into one registered write per cycle:
- single-cycle ALU results, which have no backpressure;
- multi-cycle memory/mul-div results, which use a valid/ready handshake.
Deferred memory results are held in a small FIFO. The block exports a pending-register mask so the hazard logic can stall dependent reads.

Parameters:
DATA_WIDTH, 32, width of result data and register-file write data
INDEX_WIDTH, 5, register index width (2**INDEX_WIDTH architectural registers)
FIFO_DEPTH, 2, number of deferred memory-result entries (power of two, >= 2)

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst  in  1  reset; asynchronous, active-low
i_alu_valid  in  1  ALU result present this cycle; always accepted
i_alu_index  in  INDEX_WIDTH  ALU destination register
i_alu_data  in  DATA_WIDTH  ALU result
i_mem_valid  in  1  memory-side result offered
o_mem_ready  out  1  memory-side result accepted when valid & ready
i_mem_index  in  INDEX_WIDTH  memory-side destination register
i_mem_data  in  DATA_WIDTH  memory-side result
o_wr_enable  out  1  register-file write enable (registered)
o_wr_index  out  INDEX_WIDTH  register-file write index (registered)
o_wr_data  out  DATA_WIDTH  register-file write data (registered)
o_pending  out  2**INDEX_WIDTH  bit r set while any FIFO entry targets register r
o_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset:
  - Asynchronous and active-low. While i_rst is low: o_wr_enable=0, o_wr_index=0, o_wr_data=0, FIFO empty, o_count=0, o_pending=0, o_mem_ready=0.
  - Asserting i_rst mid-operation discards all queued entries. No write is issued for a discarded entry.
- Latency: a selected result appears on o_wr_* on the edge after it is presented or popped, i.e. 1 cycle. o_wr_enable is high for exactly that one cycle.
- o_mem_ready = reset released & (count < FIFO_DEPTH). It depends only on registered count, with no pop-through when full.
- Per-cycle selection, highest priority first:
  1. ALU: i_alu_valid & (i_alu_index != 0) → write ALU result.
  2. FIFO non-empty → pop head and write it.
  3. Bypass: FIFO empty & mem handshake fires → write the memory result directly; it is not enqueued.
  4. Otherwise → o_wr_enable=0, and o_wr_index/o_wr_data hold their previous values.
- Enqueue: the mem handshake fires and the result is not consumed by bypass.
  - Push and pop in the same cycle: count unchanged, and the head advances.
  - Ordering is FIFO; memory results are never reordered among themselves.
- Register x0:
  - ALU results with index 0 are dropped and do not block the FIFO pop.
  - Memory results with index 0 are accepted (ready honoured) but neither enqueued nor written.
- o_pending is combinational from the valid FIFO entries. A bypassed result never sets pending.
- Program ordering between ALU and memory results to the same register is the issue stage's responsibility, enforced via o_pending. This block does not compare indices.
- Pointers wrap modulo FIFO_DEPTH. Count saturation is impossible because ready gates pushes.

Decomposition:
- Shared package regs_pkg: DATA_WIDTH/INDEX_WIDTH defaults, NUM_REGS = 2**INDEX_WIDTH, typedef wb_entry_t {index, data}.
- One sub-module wb_fifo: parameterised synchronous FIFO of wb_entry_t with push/pop/count/full/empty and an entry-valid vector. The arbiter derives o_pending from that vector.

Test Plan:
- Reset release, then ALU valid, index 3, data 0x11 → next cycle o_wr_enable=1, o_wr_index=3, o_wr_data=0x11; one cycle later o_wr_enable=0.
- FIFO empty, no ALU, mem valid, index 7, data 0xAA → next cycle write x7=0xAA; o_count stays 0; o_pending stays 0.
- ALU valid (x1=0x1) every cycle for 3 cycles, while mem offers x5=0x5, x6=0x6, x9=0x9 back-to-back → ready drops after 2 accepts; o_pending bits 5 and 6 set. Once the ALU stops, x5 then x6 are written on consecutive cycles; x9 is accepted when ready returns.
- ALU index 0 with data 0xFF plus FIFO holding x4=0x44 → next cycle write x4=0x44; no write of 0xFF.
- Mem index 0 offered while FIFO empty → ready=1, handshake completes, o_count=0, no write.
- FIFO full (count=2), assert i_rst low mid-cycle → outputs clear immediately; after release o_count=0, o_pending=0, and no stale writes appear.

Source files
------------

// File: rtl/regs_pkg.sv
// Shared register-file definitions: default widths, register count and the
// writeback entry type carried through the deferred-result queue.
package regs_pkg;

   localparam int DEFAULT_DATA_WIDTH  = 32;
   localparam int DEFAULT_INDEX_WIDTH = 5;
   localparam int NUM_REGS            = 2 ** DEFAULT_INDEX_WIDTH;

   // One pending register-file write: destination register plus result.
   typedef struct packed {
      logic [DEFAULT_INDEX_WIDTH-1:0] index;
      logic [DEFAULT_DATA_WIDTH-1:0]  data;
   } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Producer-side and register-file-side signals of the writeback arbiter.
// The arbiter takes the slave view; producers and benches drive the master view.
interface wb_arbiter_if
   import regs_pkg::*;
#(
   parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
   parameter int FIFO_DEPTH  = 2
);

   localparam int REG_COUNT   = 2 ** INDEX_WIDTH;
   localparam int COUNT_WIDTH = $clog2(FIFO_DEPTH) + 1;

   // ALU result stream, no backpressure
   logic                   i_alu_valid;
   logic [INDEX_WIDTH-1:0] i_alu_index;
   logic [DATA_WIDTH-1:0]  i_alu_data;

   // memory / mul-div result stream, valid/ready handshake
   logic                   i_mem_valid;
   logic                   o_mem_ready;
   logic [INDEX_WIDTH-1:0] i_mem_index;
   logic [DATA_WIDTH-1:0]  i_mem_data;

   // register-file write port and hazard information
   logic                   o_wr_enable;
   logic [INDEX_WIDTH-1:0] o_wr_index;
   logic [DATA_WIDTH-1:0]  o_wr_data;
   logic [REG_COUNT-1:0]   o_pending;
   logic [COUNT_WIDTH-1:0] o_count;

   modport master (
      output i_alu_valid, i_alu_index, i_alu_data,
      output i_mem_valid, i_mem_index, i_mem_data,
      input  o_mem_ready,
      input  o_wr_enable, o_wr_index, o_wr_data, o_pending, o_count
   );

   modport slave (
      input  i_alu_valid, i_alu_index, i_alu_data,
      input  i_mem_valid, i_mem_index, i_mem_data,
      output o_mem_ready,
      output o_wr_enable, o_wr_index, o_wr_data, o_pending, o_count
   );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO for deferred writeback entries. Besides the usual
// head/count/full/empty it exposes every slot and a per-slot valid vector so
// the owner can see which destinations are still in flight.
module wb_fifo
   import regs_pkg::*;
#(
   parameter int  DEPTH   = 2,
   parameter type entry_t = wb_entry_t
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  entry_t                     push_data,
   input  logic                       pop,
   output entry_t                     head,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output entry_t [DEPTH-1:0]         slots,
   output logic   [DEPTH-1:0]         slot_valid
);

   localparam int PTR_WIDTH   = $clog2(DEPTH);
   localparam int COUNT_WIDTH = PTR_WIDTH + 1;

   entry_t [DEPTH-1:0]     mem;
   logic [PTR_WIDTH-1:0]   wr_ptr;
   logic [PTR_WIDTH-1:0]   rd_ptr;
   logic [COUNT_WIDTH-1:0] count_q;
   logic [PTR_WIDTH-1:0]   offset;
   logic                   do_push;
   logic                   do_pop;

   assign full    = (count_q == COUNT_WIDTH'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   assign head  = mem[rd_ptr];
   assign count = count_q;
   assign slots = mem;

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   // NOTE: state registers use <= so every flop samples pre-edge values; blocking here would chain updates within one edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count_q <= count_q + COUNT_WIDTH'(do_push) - COUNT_WIDTH'(do_pop);
      end
   end

   // Entry storage, written at the tail on every accepted push.
   // NOTE: the array is deliberately not reset; slot_valid masks stale contents so nothing downstream can observe them.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // A slot is live when its distance from the head is below the occupancy.
   always_comb begin
      // NOTE: defaults before the loop keep every path assigned, so no latch is inferred.
      offset     = '0;
      slot_valid = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset        = PTR_WIDTH'(i) - rd_ptr;
         slot_valid[i] = ({1'b0, offset} < count_q);
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter in front of the integer register file. Merges the
// always-accepted ALU stream and the handshaked memory stream into one
// registered write per cycle, parking memory results in a small FIFO when the
// ALU owns the port, and reports which registers still have queued writes.
module wb_arbiter
   import regs_pkg::*;
#(
   parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
   parameter int FIFO_DEPTH  = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   wb_arbiter_if.slave bus
);

   localparam int REG_COUNT   = 2 ** INDEX_WIDTH;
   localparam int COUNT_WIDTH = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic [INDEX_WIDTH-1:0] index;
      logic [DATA_WIDTH-1:0]  data;
   } entry_t;

   entry_t                  mem_entry;
   entry_t                  head;
   entry_t [FIFO_DEPTH-1:0] slots;
   logic   [FIFO_DEPTH-1:0] slot_valid;
   logic [COUNT_WIDTH-1:0]  count;
   logic                    full;
   logic                    empty;

   logic                    mem_ready;
   logic                    alu_fire;
   logic                    mem_live;
   logic                    pop;
   logic                    bypass;
   logic                    push;

   logic                    wr_enable;
   logic [INDEX_WIDTH-1:0]  wr_index;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic [REG_COUNT-1:0]    pending;

   // Ready looks only at registered occupancy: a full queue never accepts,
   // even if the head leaves this cycle.
   assign mem_ready = i_rst & ~full;

   // x0 writes are architecturally void, so such results never count as work.
   assign alu_fire = bus.i_alu_valid & (bus.i_alu_index != '0);
   assign mem_live = bus.i_mem_valid & mem_ready & (bus.i_mem_index != '0);

   // Priority: ALU, then queued memory results, then a direct memory bypass.
   assign pop    = ~alu_fire & ~empty;
   assign bypass = ~alu_fire & empty & mem_live;
   assign push   = mem_live & ~bypass;

   assign mem_entry.index = bus.i_mem_index;
   assign mem_entry.data  = bus.i_mem_data;

   wb_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk        (i_clk),
      .rst_n      (i_rst),
      .push       (push),
      .push_data  (mem_entry),
      .pop        (pop),
      .head       (head),
      .count      (count),
      .full       (full),
      .empty      (empty),
      .slots      (slots),
      .slot_valid (slot_valid)
   );

   // Registered write port; index/data hold their last value on idle cycles.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         wr_enable <= 1'b0;
         wr_index  <= '0;
         wr_data   <= '0;
      end else begin
         wr_enable <= alu_fire | pop | bypass;
         if (alu_fire) begin
            wr_index <= bus.i_alu_index;
            wr_data  <= bus.i_alu_data;
         end else if (pop) begin
            wr_index <= head.index;
            wr_data  <= head.data;
         end else if (bypass) begin
            wr_index <= bus.i_mem_index;
            wr_data  <= bus.i_mem_data;
         end
      end
   end

   // Destinations of every queued entry, for the issue-stage hazard check.
   always_comb begin
      pending = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (slot_valid[i]) pending[slots[i].index] = 1'b1;
      end
   end

   assign bus.o_mem_ready = mem_ready;
   assign bus.o_wr_enable = wr_enable;
   assign bus.o_wr_index  = wr_index;
   assign bus.o_wr_data   = wr_data;
   assign bus.o_pending   = pending;
   assign bus.o_count     = count;

endmodule
